siphash_core: RTL

- Parametrised SipHash-c-d engine with a command-driven key load, message compression and finalisation path.
- Supports 64-bit or 128-bit output, a result-valid pulse, and dropped-command reporting.
- Executes one SipRound per clock through a combinational round sub-module.
- Sits behind the host command bus as the next-generation hashing core, replacing the fixed 2-4, 64-bit-only engine.

---
 rtl/siphash_pkg.sv | 33 +++
 rtl/siphash_core_round.sv | 28 ++
 rtl/siphash_core.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/siphash_pkg.sv
// Shared constants, opcodes and types for the SipHash engine.
// Also holds the 64-bit rotate helper used by the round logic.
package siphash_pkg;

    localparam logic [3:0] OP_KEY_LO   = 4'h0;
    localparam logic [3:0] OP_KEY_HI   = 4'h1;
    localparam logic [3:0] OP_COMPRESS = 4'h2;
    localparam logic [3:0] OP_FINAL    = 4'h3;

    localparam logic [63:0] IV0 = 64'h736f6d6570736575;
    localparam logic [63:0] IV1 = 64'h646f72616e646f6d;
    localparam logic [63:0] IV2 = 64'h6c7967656e657261;
    localparam logic [63:0] IV3 = 64'h7465646279746573;

    localparam logic [63:0] FIN_FF = 64'h00000000000000ff;
    localparam logic [63:0] FIN_EE = 64'h00000000000000ee;
    localparam logic [63:0] FIN_DD = 64'h00000000000000dd;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COMP = 2'd1,
        FIN1 = 2'd2,
        FIN2 = 2'd3
    } state_t;

    // Index 0..3 maps to v0..v3.
    typedef logic [3:0][63:0] sip_state_t;

    function automatic logic [63:0] rotl64(input logic [63:0] x, input int unsigned n);
        return (x << n) | (x >> (64 - n));
    endfunction

endpackage

// File: rtl/siphash_core_round.sv
// One combinational SipRound over the four 64-bit state words.
module sip_round
    import siphash_pkg::*;
(
    input  sip_state_t v_in,
    output sip_state_t v_out
);

    logic [63:0] a0, a1, a2, a3, a0_rot;
    logic [63:0] b0, b1, b2, b3;

    assign a0     = v_in[0] + v_in[1];
    assign a1     = rotl64(v_in[1], 13) ^ a0;
    assign a0_rot = rotl64(a0, 32);
    assign a2     = v_in[2] + v_in[3];
    assign a3     = rotl64(v_in[3], 16) ^ a2;

    assign b0 = a0_rot + a3;
    assign b3 = rotl64(a3, 21) ^ b0;
    assign b2 = a2 + a1;
    assign b1 = rotl64(a1, 17) ^ b2;

    assign v_out[0] = b0;
    assign v_out[1] = b1;
    assign v_out[2] = rotl64(b2, 32);
    assign v_out[3] = b3;

endmodule

// File: rtl/siphash_core.sv
// SipHash-c-d engine: command-driven key load, compression and finalisation,
// one SipRound per clock, optional 128-bit output.
module siphash_core
    import siphash_pkg::*;
#(
    parameter int unsigned C       = 2,
    parameter int unsigned D       = 4,
    parameter bit          OUT_128 = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         we,
    input  logic [67:0]  cmd,
    output logic         busy,
    output logic         result_valid,
    output logic [127:0] result,
    output logic         cmd_err
);

    localparam logic [3:0]  C_INIT    = 4'(C);
    localparam logic [3:0]  D_INIT    = 4'(D);
    localparam logic [63:0] KEY_TWEAK = OUT_128 ? FIN_EE : 64'h0;
    localparam logic [63:0] V2_TWEAK  = OUT_128 ? FIN_EE : FIN_FF;

    state_t       state_reg, state_next;
    sip_state_t   v_reg, v_next, round_out;
    logic [3:0]   cnt_reg, cnt_next;
    logic [63:0]  m_reg, m_next;
    logic         final_reg, final_next;
    logic [127:0] result_reg, result_next;
    logic         result_valid_reg, result_valid_next;
    logic         cmd_err_reg, cmd_err_next;

    logic [3:0]   op;
    logic [63:0]  data;
    logic [63:0]  fold;
    logic         last_round;

    assign op   = cmd[67:64];
    assign data = cmd[63:0];

    sip_round u_round (
        .v_in  (v_reg),
        .v_out (round_out)
    );

    // Digest word is the xor of the state as it leaves the last round.
    assign fold       = round_out[0] ^ round_out[1] ^ round_out[2] ^ round_out[3];
    assign last_round = (cnt_reg == 4'd1);

    always_comb begin
        state_next        = state_reg;
        v_next            = v_reg;
        cnt_next          = cnt_reg;
        m_next            = m_reg;
        final_next        = final_reg;
        result_next       = result_reg;
        result_valid_next = 1'b0;
        cmd_err_next      = 1'b0;

        case (state_reg)
            IDLE: begin
                if (we) begin
                    case (op)
                        OP_KEY_LO: begin
                            v_next[0] = data ^ IV0;
                            v_next[2] = data ^ IV2;
                        end
                        OP_KEY_HI: begin
                            v_next[1] = data ^ IV1 ^ KEY_TWEAK;
                            v_next[3] = data ^ IV3;
                        end
                        OP_COMPRESS, OP_FINAL: begin
                            v_next[3]  = v_reg[3] ^ data;
                            m_next     = data;
                            cnt_next   = C_INIT;
                            final_next = (op == OP_FINAL);
                            state_next = COMP;
                        end
                        default: cmd_err_next = 1'b1;
                    endcase
                end
            end
            COMP: begin
                v_next   = round_out;
                cnt_next = cnt_reg - 4'd1;
                if (last_round) begin
                    v_next[0] = round_out[0] ^ m_reg;
                    if (final_reg) begin
                        v_next[2]  = round_out[2] ^ V2_TWEAK;
                        cnt_next   = D_INIT;
                        state_next = FIN1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            FIN1: begin
                v_next   = round_out;
                cnt_next = cnt_reg - 4'd1;
                if (last_round) begin
                    result_next[63:0] = fold;
                    if (OUT_128) begin
                        v_next[1]  = round_out[1] ^ FIN_DD;
                        cnt_next   = D_INIT;
                        state_next = FIN2;
                    end else begin
                        result_valid_next = 1'b1;
                        state_next        = IDLE;
                    end
                end
            end
            FIN2: begin
                v_next   = round_out;
                cnt_next = cnt_reg - 4'd1;
                if (last_round) begin
                    result_next[127:64] = fold;
                    result_valid_next   = 1'b1;
                    state_next          = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // Commands arriving mid-operation are dropped without side effects.
        if (we && (state_reg != IDLE)) begin
            cmd_err_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            v_reg            <= '0;
            cnt_reg          <= '0;
            m_reg            <= '0;
            final_reg        <= 1'b0;
            result_reg       <= '0;
            result_valid_reg <= 1'b0;
            cmd_err_reg      <= 1'b0;
        end else begin
            state_reg        <= state_next;
            v_reg            <= v_next;
            cnt_reg          <= cnt_next;
            m_reg            <= m_next;
            final_reg        <= final_next;
            result_reg       <= result_next;
            result_valid_reg <= result_valid_next;
            cmd_err_reg      <= cmd_err_next;
        end
    end

    assign busy         = (state_reg != IDLE);
    assign result_valid = result_valid_reg;
    assign result       = result_reg;
    assign cmd_err      = cmd_err_reg;

endmodule
